dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one data-memory port between two requesters: port 0 is the cpu load/store path,
//  port 1 is a secondary master (debug/DMA loader). Each port has a req/gnt handshake.
//  Read data returns on a fixed-latency tagged pipeline. Sits between cpu/loader and the data RAM.
// PARAMETERS
//  AW          16  address width (matches DADDRWIDTH)
//  DW          16  data width (matches DWIDTH)
//  RD_LATENCY  1   cycles from mem_re to valid mem_rdata; legal 1..4
// PORTS
//  clk         in   1   clock, all state on posedge
//  rst         in   1   reset, asynchronous, active-high
//  p0_req      in   1   port 0 requests a transaction
//  p0_we       in   1   port 0 transaction is a write (0 = read)
//  p0_addr     in   AW  port 0 address
//  p0_wdata    in   DW  port 0 write data
//  p0_gnt      out  1   port 0 transaction issued this cycle
//  p0_rvalid   out  1   port 0 read data valid
//  p0_rdata    out  DW  port 0 read data
//  p1_*        same set as p0_* for port 1
//  mem_re      out  1   memory read strobe
//  mem_raddr   out  AW  memory read address
//  mem_we      out  1   memory write strobe
//  mem_waddr   out  AW  memory write address
//  mem_wdata   out  DW  memory write data
//  mem_rdata   in   DW  memory read data, valid RD_LATENCY cycles after mem_re
// BEHAVIOUR
//  - Reset (async): rr pointer=0 (port 0 favoured), read-tag pipeline cleared; while rst high all
//    gnt, rvalid, mem_re, mem_we = 0; addr/data outputs don't-care (drive 0).
//  - Max one transaction issued per cycle, read or write. Grant is combinational in the req cycle;
//    mem strobes/address/data are a combinational mux of the granted port in the same cycle.
//  - Requester holds req/we/addr/wdata stable until the cycle gnt is high; txn completes that edge.
//  - Only one req: that port granted. Both req: without ROUND_ROBIN_EN port 0 always wins.
//  - Non-granted req is held off (gnt=0); nothing is queued inside the arbiter.
//  - Granted read pushes {valid=1, port id} into a RD_LATENCY-deep shift register; otherwise pushes
//    valid=0. On the stage-RD_LATENCY output, pN_rvalid=1 for tagged port, pN_rdata=mem_rdata
//    (both ports see mem_rdata on rdata; only rvalid is qualified).
//  - Back-to-back reads from either port every cycle are legal; returns stay in issue order.
//  - Write followed next cycle by read of same address: ordering is the memory's; arbiter adds none.
//  - Reset mid-operation: in-flight read tags discarded; no rvalid after rst deasserts for reads
//    issued before reset.
//  - No address arithmetic; addresses pass through unmodified, width AW, no wrap handling needed.
// CONFIGURATION
//  - DMEM_ARB_ROUND_ROBIN_EN defined: on contention, the port not granted last contended cycle wins;
//    rr pointer updates only on cycles where both req and a grant occurs (points to loser).
//    Uncontended grants do not move the pointer.
//  - Undefined: fixed priority, port 0 over port 1; rr pointer logic absent.
// TESTING
//  - Reset: assert rst mid-cycle with p0_req=1 -> p0_gnt, mem_re, mem_we drop immediately, stay 0.
//  - p0 read addr 0x0010, mem holds 0xBEEF, RD_LATENCY=1 -> p0_gnt same cycle, p0_rvalid next cycle
//    with p0_rdata=0xBEEF; p1_rvalid stays 0.
//  - p1 write addr 0x0020 data 0x1234 alone -> p1_gnt=1, mem_we=1, mem_waddr=0x0020, wdata=0x1234.
//  - Both req reads 4 cycles held: fixed priority -> p0 gnt all 4, p1 0; RR -> grants alternate
//    p0,p1,p0,p1 and rvalid returns in same order.
//  - RD_LATENCY=3, reads issued cycles 0,1,2 (p0,p1,p0) -> rvalid cycles 3,4,5 on p0,p1,p0.
//  - Read granted, rst pulsed next cycle -> no rvalid ever returned for that read.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// One requester-side data-memory port: req/gnt handshake plus tagged read return.
// master = requester (cpu or loader), slave = arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with a fixed-latency tagged read-return pipeline.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise port 0 has priority.
module dmem_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic          mem_re,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          gnt0, gnt1, issue;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rd_issue;

  logic [RD_LATENCY-1:0] tag_valid_q, tag_port_q;
  logic [RD_LATENCY:0]   tag_valid_shift, tag_port_shift;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Port favoured on the next contended cycle (the loser of the last one).
  logic rr_q;

  always_comb begin
    gnt0 = ~rst & p0.req & (~p1.req | ~rr_q);
    gnt1 = ~rst & p1.req & (~p0.req | rr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (p0.req && p1.req && (gnt0 || gnt1)) begin
      rr_q <= gnt0;
    end
  end
`else
  always_comb begin
    gnt0 = ~rst & p0.req;
    gnt1 = ~rst & p1.req & ~p0.req;
  end
`endif

  always_comb begin
    issue     = gnt0 | gnt1;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt1) begin
      sel_we    = p1.we;
      sel_addr  = p1.addr;
      sel_wdata = p1.wdata;
    end else if (gnt0) begin
      sel_we    = p0.we;
      sel_addr  = p0.addr;
      sel_wdata = p0.wdata;
    end
    rd_issue  = issue & ~sel_we;
  end

  assign p0.gnt    = gnt0;
  assign p1.gnt    = gnt1;
  assign mem_re    = rd_issue;
  assign mem_we    = issue & sel_we;
  assign mem_raddr = sel_addr;
  assign mem_waddr = sel_addr;
  assign mem_wdata = sel_wdata;

  // Stage 0 takes the current issue; the top stage lines up with mem_rdata.
  assign tag_valid_shift = {tag_valid_q, rd_issue};
  assign tag_port_shift  = {tag_port_q, gnt1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= '0;
      tag_port_q  <= '0;
    end else begin
      tag_valid_q <= tag_valid_shift[RD_LATENCY-1:0];
      tag_port_q  <= tag_port_shift[RD_LATENCY-1:0];
    end
  end

  assign p0.rvalid = tag_valid_q[RD_LATENCY-1] & ~tag_port_q[RD_LATENCY-1];
  assign p1.rvalid = tag_valid_q[RD_LATENCY-1] & tag_port_q[RD_LATENCY-1];
  assign p0.rdata  = rst ? '0 : mem_rdata;
  assign p1.rdata  = rst ? '0 : mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=3.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.AW(16), .DW(16)) a0 ();
  dmem_arbiter_if #(.AW(16), .DW(16)) a1 ();
  dmem_arbiter_if #(.AW(16), .DW(16)) b0 ();
  dmem_arbiter_if #(.AW(16), .DW(16)) b1 ();

  logic        m_re, m_we, n_re, n_we;
  logic [15:0] m_raddr, m_waddr, m_wdata, m_rdata;
  logic [15:0] n_raddr, n_waddr, n_wdata, n_rdata;

  dmem_arbiter #(.AW(16), .DW(16), .RD_LATENCY(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (a0),
    .p1        (a1),
    .mem_re    (m_re),
    .mem_raddr (m_raddr),
    .mem_we    (m_we),
    .mem_waddr (m_waddr),
    .mem_wdata (m_wdata),
    .mem_rdata (m_rdata)
  );

  dmem_arbiter #(.AW(16), .DW(16), .RD_LATENCY(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .p0        (b0),
    .p1        (b1),
    .mem_re    (n_re),
    .mem_raddr (n_raddr),
    .mem_we    (n_we),
    .mem_waddr (n_waddr),
    .mem_wdata (n_wdata),
    .mem_rdata (n_rdata)
  );

  // Behavioural RAM shared by both instances; only dut writes it.
  logic [15:0] mem [256];
  logic [15:0] rd1, r3a, r3b, r3c;

  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'h0000;
      mem[8'h30] <= 16'h5A5A;
    end else if (m_we) begin
      mem[m_waddr[7:0]] <= m_wdata;
    end
    rd1 <= mem[m_raddr[7:0]];
    r3a <= mem[n_raddr[7:0]];
    r3b <= r3a;
    r3c <= r3b;
  end

  assign m_rdata = rd1;
  assign n_rdata = r3c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp1, prev1;

  initial begin
    a0.req = 0; a0.we = 0; a0.addr = 0; a0.wdata = 0;
    a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0;
    b1.req = 0; b1.we = 0; b1.addr = 0; b1.wdata = 0;
    prev1 = 0;

    // Held in reset with a pending request
    tick();
    a0.req = 1; a0.addr = 16'h0010;
    #1;
    chk("rst_gnt0", a0.gnt, 0);
    chk("rst_mem_re", m_re, 0);
    chk("rst_rvalid0", a0.rvalid, 0);
    tick();
    rst = 0;
    #1;
    chk("pre_gnt0", a0.gnt, 1);
    chk("pre_mem_re", m_re, 1);
    chk("pre_raddr", m_raddr, 16'h0010);
    #2 rst = 1;
    #1;
    chk("midrst_gnt0", a0.gnt, 0);
    chk("midrst_mem_re", m_re, 0);
    chk("midrst_mem_we", m_we, 0);
    chk("midrst_raddr", m_raddr, 0);
    tick();
    chk("midrst_gnt0_hold", a0.gnt, 0);
    a0.req = 0;
    rst = 0;
    tick();
    chk("postrst_rvalid0", a0.rvalid, 0);
    chk("postrst_rvalid1", a1.rvalid, 0);

    // Single p0 read
    a0.req = 1; a0.we = 0; a0.addr = 16'h0010;
    #1;
    chk("rd_gnt0", a0.gnt, 1);
    chk("rd_gnt1", a1.gnt, 0);
    chk("rd_mem_re", m_re, 1);
    chk("rd_mem_we", m_we, 0);
    tick();
    a0.req = 0;
    #1;
    chk("rd_rvalid0", a0.rvalid, 1);
    chk("rd_rdata0", a0.rdata, 16'hBEEF);
    chk("rd_rvalid1", a1.rvalid, 0);
    tick();
    chk("rd_rvalid0_done", a0.rvalid, 0);

    // Single p1 write, then read it back
    a1.req = 1; a1.we = 1; a1.addr = 16'h0020; a1.wdata = 16'h1234;
    #1;
    chk("wr_gnt1", a1.gnt, 1);
    chk("wr_gnt0", a0.gnt, 0);
    chk("wr_mem_we", m_we, 1);
    chk("wr_mem_re", m_re, 0);
    chk("wr_waddr", m_waddr, 16'h0020);
    chk("wr_wdata", m_wdata, 16'h1234);
    tick();
    a1.we = 0;
    #1;
    chk("rb_gnt1", a1.gnt, 1);
    chk("rb_raddr", m_raddr, 16'h0020);
    tick();
    a1.req = 0;
    #1;
    chk("rb_rvalid1", a1.rvalid, 1);
    chk("rb_rdata1", a1.rdata, 16'h1234);
    chk("rb_rvalid0", a0.rvalid, 0);
    tick();

    // Both ports read for four cycles
    a0.req = 1; a0.we = 0; a0.addr = 16'h0010;
    a1.req = 1; a1.we = 0; a1.addr = 16'h0020;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      chk("cont_gnt0", a0.gnt, !exp1);
      chk("cont_gnt1", a1.gnt, exp1);
      if (k > 0) begin
        chk("cont_rvalid0", a0.rvalid, !prev1);
        chk("cont_rvalid1", a1.rvalid, prev1);
        chk("cont_rdata", a0.rdata, prev1 ? 16'h1234 : 16'hBEEF);
      end
      prev1 = exp1;
      tick();
    end
    a0.req = 0; a1.req = 0;
    #1;
    chk("cont_last_rvalid0", a0.rvalid, !prev1);
    chk("cont_last_rvalid1", a1.rvalid, prev1);
    tick();

    // RD_LATENCY=3: p0, p1, p0 back to back
    b0.req = 1; b0.addr = 16'h0010;
    #1;
    chk("l3_gnt0_c0", b0.gnt, 1);
    tick();
    b0.req = 0; b1.req = 1; b1.addr = 16'h0020;
    #1;
    chk("l3_gnt1_c1", b1.gnt, 1);
    chk("l3_rvalid0_c1", b0.rvalid, 0);
    tick();
    b1.req = 0; b0.req = 1; b0.addr = 16'h0030;
    #1;
    chk("l3_gnt0_c2", b0.gnt, 1);
    chk("l3_rvalid0_c2", b0.rvalid, 0);
    chk("l3_rvalid1_c2", b1.rvalid, 0);
    tick();
    b0.req = 0;
    #1;
    chk("l3_rvalid0_c3", b0.rvalid, 1);
    chk("l3_rvalid1_c3", b1.rvalid, 0);
    chk("l3_rdata_c3", b0.rdata, 16'hBEEF);
    tick();
    chk("l3_rvalid1_c4", b1.rvalid, 1);
    chk("l3_rvalid0_c4", b0.rvalid, 0);
    chk("l3_rdata_c4", b1.rdata, 16'h1234);
    tick();
    chk("l3_rvalid0_c5", b0.rvalid, 1);
    chk("l3_rdata_c5", b0.rdata, 16'h5A5A);
    tick();
    chk("l3_rvalid0_c6", b0.rvalid, 0);
    chk("l3_rvalid1_c6", b1.rvalid, 0);

    // RD_LATENCY=3: read granted, reset pulsed next cycle
    b0.req = 1; b0.addr = 16'h0010;
    #1;
    chk("l3rst_gnt0", b0.gnt, 1);
    tick();
    b0.req = 0;
    rst = 1;
    #1;
    chk("l3rst_rvalid0_inrst", b0.rvalid, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("l3rst_rvalid0", b0.rvalid, 0);
      chk("l3rst_rvalid1", b1.rvalid, 0);
      tick();
    end

    // RD_LATENCY=1: reset while a return is visible clears it at once
    a0.req = 1; a0.addr = 16'h0010;
    tick();
    a0.req = 0;
    #1;
    chk("l1rst_rvalid0_before", a0.rvalid, 1);
    rst = 1;
    #1;
    chk("l1rst_rvalid0_after", a0.rvalid, 0);
    tick();
    rst = 0;
    tick();
    chk("l1rst_rvalid0_released", a0.rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
